// File: rtl/generate_pipeline_pkg.sv
// generate_pipeline_pkg: shared helpers for the elastic register pipeline
package generate_pipeline_pkg;
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/generate_pipeline_stage.sv
// generate_pipeline_stage: one valid/data register slot of the elastic pipeline
module generate_pipeline_stage
  import generate_pipeline_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  // data only moves with a valid beat so idle cycles do not toggle it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/generate_pipeline.sv
// generate_pipeline: elastic DEPTH-stage valid/ready pipeline with bubble collapsing.
// Define GENERATE_PIPELINE_FLUSH_EN to add a synchronous i_flush that empties every stage.
module generate_pipeline
  import generate_pipeline_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
`ifdef GENERATE_PIPELINE_FLUSH_EN
  input  logic                          i_flush,
`endif
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [WIDTH-1:0]              i_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [WIDTH-1:0]              o_data,
  output logic [count_width(DEPTH)-1:0] o_count
);
  localparam int CW = count_width(DEPTH);
  if (DEPTH == 0) begin : g_pass
    assign o_valid = i_valid;
    assign o_ready = i_ready;
    assign o_data  = i_data;
    assign o_count = '0;
  end else begin : g_pipe
    logic             w_flush;
    logic [DEPTH:0]   w_rdy;
    logic [DEPTH-1:0] w_vq;
    logic [DEPTH:0]   w_sv;
    logic [WIDTH-1:0] w_sd [DEPTH+1];
    logic             w_in;
    logic             w_out;
    logic [CW-1:0]    r_count;
`ifdef GENERATE_PIPELINE_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif
    // a stage can load when it is empty or everything below it moves
    always_comb begin
      w_rdy        = '0;
      w_rdy[DEPTH] = i_ready;
      for (int k = DEPTH - 1; k >= 0; k--) w_rdy[k] = !w_vq[k] || w_rdy[k+1];
    end
    assign w_sv    = {w_vq, i_valid};
    assign w_sd[0] = i_data;
    for (genvar k = 0; k < DEPTH; k++) begin : stage_gen
      generate_pipeline_stage #(.WIDTH(WIDTH)) u_stage (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_rdy[k] || w_flush),
        .i_valid (w_sv[k] && !w_flush),
        .i_data  (w_sd[k]),
        .o_valid (w_vq[k]),
        .o_data  (w_sd[k+1])
      );
    end
    assign o_ready = w_rdy[0] && !w_flush;
    assign o_valid = w_vq[DEPTH-1];
    assign o_data  = w_sd[DEPTH];
    assign w_in    = i_valid && o_ready;
    assign w_out   = o_valid && i_ready;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_count <= '0;
      else if (w_flush) r_count <= '0;
      else if (w_in && !w_out) r_count <= r_count + CW'(1);
      else if (w_out && !w_in) r_count <= r_count - CW'(1);
    end
    assign o_count = r_count;
    always @(posedge i_clk) begin
      if (i_rst_n) assert (int'(r_count) == $countones(w_vq));
    end
  end
endmodule

// File: tb/tb_generate_pipeline.sv
// tb_generate_pipeline: table-driven check of the elastic pipeline plus reset, passthrough and flush sequences
module tb_generate_pipeline;
  import generate_pipeline_pkg::*;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = count_width(D);
  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         ov;
    logic [W-1:0] od;
    logic         rdy;
    logic [2:0]   cnt;
  } vec_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iv = 1'b0;
  logic          ir = 1'b0;
  logic [W-1:0]  id = '0;
  logic          ov;
  logic          ordy;
  logic [W-1:0]  od;
  logic [CW-1:0] cnt;
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [W-1:0]  pd = '0;
  logic          pov;
  logic          pordy;
  logic [W-1:0]  pod;
  logic [0:0]    pcnt;
`ifdef GENERATE_PIPELINE_FLUSH_EN
  logic          flush = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  always #5 clk = ~clk;
  generate_pipeline #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
`ifdef GENERATE_PIPELINE_FLUSH_EN
    .i_flush (flush),
`endif
    .i_valid (iv),
    .o_ready (ordy),
    .i_data  (id),
    .o_valid (ov),
    .i_ready (ir),
    .o_data  (od),
    .o_count (cnt)
  );
  generate_pipeline #(.WIDTH(W), .DEPTH(0)) dut_pass (
    .i_clk   (clk),
    .i_rst_n (rst_n),
`ifdef GENERATE_PIPELINE_FLUSH_EN
    .i_flush (1'b0),
`endif
    .i_valid (pv),
    .o_ready (pordy),
    .i_data  (pd),
    .o_valid (pov),
    .i_ready (pr),
    .o_data  (pod),
    .o_count (pcnt)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask
  task automatic add(input logic v, input logic [7:0] d, input logic r,
                     input logic eov, input logic [7:0] eod, input logic erdy, input logic [2:0] ecnt);
    vecs.push_back('{v, d, r, eov, eod, erdy, ecnt});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    // streaming with no backpressure: latency 4, count peaks at 3
    add(1, 8'h11, 1, 0, 8'h00, 1, 0);
    add(1, 8'h22, 1, 0, 8'h00, 1, 1);
    add(1, 8'h33, 1, 0, 8'h00, 1, 2);
    add(0, 8'h00, 1, 0, 8'h00, 1, 3);
    add(0, 8'h00, 1, 1, 8'h11, 1, 3);
    add(0, 8'h00, 1, 1, 8'h22, 1, 2);
    add(0, 8'h00, 1, 1, 8'h33, 1, 1);
    add(0, 8'h00, 1, 0, 8'h00, 1, 0);
    // stalled fill, then simultaneous in/out on a full pipe, then drain
    add(1, 8'h01, 0, 0, 8'h00, 1, 0);
    add(1, 8'h02, 0, 0, 8'h00, 1, 1);
    add(1, 8'h03, 0, 0, 8'h00, 1, 2);
    add(1, 8'h04, 0, 0, 8'h00, 1, 3);
    add(1, 8'h05, 0, 1, 8'h01, 0, 4);
    add(1, 8'h06, 0, 1, 8'h01, 0, 4);
    add(1, 8'h07, 1, 1, 8'h01, 1, 4);
    add(0, 8'h00, 0, 1, 8'h02, 0, 4);
    add(0, 8'h00, 1, 1, 8'h02, 1, 4);
    add(0, 8'h00, 1, 1, 8'h03, 1, 3);
    add(0, 8'h00, 1, 1, 8'h04, 1, 2);
    add(0, 8'h00, 1, 1, 8'h07, 1, 1);
    add(0, 8'h00, 0, 0, 8'h00, 1, 0);
    // bubble at stage 1 under stall gets filled, order preserved
    add(1, 8'ha1, 0, 0, 8'h00, 1, 0);
    add(0, 8'h00, 0, 0, 8'h00, 1, 1);
    add(0, 8'h00, 0, 0, 8'h00, 1, 1);
    add(0, 8'h00, 0, 0, 8'h00, 1, 1);
    add(1, 8'hb2, 0, 1, 8'ha1, 1, 1);
    add(0, 8'h00, 0, 1, 8'ha1, 1, 2);
    add(1, 8'hc3, 0, 1, 8'ha1, 1, 2);
    add(1, 8'hd4, 0, 1, 8'ha1, 1, 3);
    add(1, 8'he5, 0, 1, 8'ha1, 0, 4);
    add(0, 8'h00, 1, 1, 8'ha1, 1, 4);
    add(0, 8'h00, 1, 1, 8'hb2, 1, 3);
    add(0, 8'h00, 1, 1, 8'hc3, 1, 2);
    add(0, 8'h00, 1, 1, 8'hd4, 1, 1);
    add(0, 8'h00, 1, 0, 8'h00, 1, 0);
    #12;
    chk("rst_valid", 32'(ov), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_data", 32'(od), 32'd0);
    chk("rst_ready", 32'(ordy), 32'd1);
    tick();
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      iv = vecs[i].v;
      id = vecs[i].d;
      ir = vecs[i].r;
      #1;
      chk($sformatf("row%0d_ready", i), 32'(ordy), 32'(vecs[i].rdy));
      chk($sformatf("row%0d_valid", i), 32'(ov), 32'(vecs[i].ov));
      chk($sformatf("row%0d_count", i), 32'(cnt), 32'(vecs[i].cnt));
      if (vecs[i].ov) chk($sformatf("row%0d_data", i), 32'(od), 32'(vecs[i].od));
      tick();
    end
    // asynchronous reset with three beats in flight
    iv = 1'b1;
    ir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id = 8'(8'ha0 + i);
      tick();
    end
    iv = 1'b0;
    chk("inflight_count", 32'(cnt), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov), 32'd0);
    chk("midrst_count", 32'(cnt), 32'd0);
    chk("midrst_data", 32'(od), 32'd0);
    chk("midrst_ready", 32'(ordy), 32'd1);
    tick();
    rst_n = 1'b1;
    iv = 1'b1;
    id = 8'h5a;
    tick();
    iv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("postrst_wait%0d", i), 32'(ov), 32'd0);
      tick();
    end
    chk("postrst_valid", 32'(ov), 32'd1);
    chk("postrst_data", 32'(od), 32'h5a);
    chk("postrst_count", 32'(cnt), 32'd1);
    tick();
    chk("postrst_empty", 32'(ov), 32'd0);
    chk("postrst_count0", 32'(cnt), 32'd0);
`ifdef GENERATE_PIPELINE_FLUSH_EN
    ir = 1'b0;
    iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      id = 8'(8'h40 + i);
      tick();
    end
    chk("flush_full", 32'(cnt), 32'd4);
    flush = 1'b1;
    ir = 1'b1;
    #1;
    chk("flush_ready", 32'(ordy), 32'd0);
    tick();
    flush = 1'b0;
    iv = 1'b0;
    chk("flush_valid", 32'(ov), 32'd0);
    chk("flush_count", 32'(cnt), 32'd0);
    chk("flush_after_ready", 32'(ordy), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      pv = 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      pd = 8'($urandom);
      #1;
      chk($sformatf("pass%0d_data", i), 32'(pod), 32'(pd));
      chk($sformatf("pass%0d_valid", i), 32'(pov), 32'(pv));
      chk($sformatf("pass%0d_ready", i), 32'(pordy), 32'(pr));
      chk($sformatf("pass%0d_count", i), 32'(pcnt), 32'd0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
